fifo_mono_arbiter: RTL and testbench

Shares one FIFO_Mono instance (8-bit word, tag in MSB) between two tagged dataflows. On the write side, a round-robin arbiter merges two valid/ready producers into the FIFO and stamps the source in the MSB (0 = flow 0, 1 = flow 1). On the read side, a small FSM pops the FIFO and steers each word to the consumer selected by its tag. Sits between the dataflow actors and the shared FIFO in the multi-dataflow datapath.

---
 rtl/fifo_arb_pkg.sv | 16 +
 rtl/rr_arb2.sv | 36 +++
 rtl/fifo_mono_arbiter.sv | 116 +++++++++++
 tb/tb_fifo_mono_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared defaults, flow tags and read-state encoding for fifo_mono_arbiter
package fifo_arb_pkg;

    localparam int DATA_W_DEF = 7;
    localparam int CNT_W_DEF  = 16;

    localparam logic TAG_FLOW0 = 1'b0;
    localparam logic TAG_FLOW1 = 1'b1;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_HOLD = 2'd2
    } rd_state_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - 2-way round-robin arbiter with combinational grant and registered priority
module rr_arb2 (
    input  logic       ck,
    input  logic       rst,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);

    logic       r_prio;
    logic [1:0] w_gnt;

    // Grants are held off while reset is asserted so nothing leaks into the FIFO.
    always_comb begin
        w_gnt = 2'b00;
        if (rst) begin
            if (i_req == 2'b11) begin
                w_gnt[r_prio] = 1'b1;
            end else begin
                w_gnt = i_req;
            end
        end
    end

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            r_prio <= 1'b0;
        end else if (w_gnt[0]) begin
            r_prio <= 1'b1;
        end else if (w_gnt[1]) begin
            r_prio <= 1'b0;
        end
    end

    assign o_gnt = w_gnt;

endmodule

// File: rtl/fifo_mono_arbiter.sv
// rtl/fifo_mono_arbiter.sv - shares one tagged FIFO between two flows: rr write merge, tag-steered read
module fifo_mono_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              ck,
    input  logic              rst,
    input  logic              in0_valid,
    input  logic [DATA_W-1:0] in0_data,
    output logic              in0_ready,
    input  logic              in1_valid,
    input  logic [DATA_W-1:0] in1_data,
    output logic              in1_ready,
    output logic              fifo_wr,
    output logic [DATA_W:0]   fifo_datain,
    input  logic              fifo_full,
    output logic              fifo_rd,
    input  logic [DATA_W:0]   fifo_dataout,
    input  logic              fifo_empty,
    output logic              out0_valid,
    output logic [DATA_W-1:0] out0_data,
    input  logic              out0_ready,
    output logic              out1_valid,
    output logic [DATA_W-1:0] out1_data,
    input  logic              out1_ready,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1
);

    logic [1:0]       w_req;
    logic [1:0]       w_gnt;
    logic [CNT_W-1:0] r_cnt0;
    logic [CNT_W-1:0] r_cnt1;

    assign w_req = {in1_valid & ~fifo_full, in0_valid & ~fifo_full};

    rr_arb2 u_arb (
        .ck    (ck),
        .rst   (rst),
        .i_req (w_req),
        .o_gnt (w_gnt)
    );

    assign in0_ready   = w_gnt[0];
    assign in1_ready   = w_gnt[1];
    assign fifo_wr     = |w_gnt;
    assign fifo_datain = w_gnt[1] ? {TAG_FLOW1, in1_data} : {TAG_FLOW0, in0_data};

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (w_gnt[0]) r_cnt0 <= r_cnt0 + 1'b1;
            if (w_gnt[1]) r_cnt1 <= r_cnt1 + 1'b1;
        end
    end

    assign cnt0 = r_cnt0;
    assign cnt1 = r_cnt1;

    rd_state_t     r_state;
    logic [DATA_W:0] r_out_reg;
    logic          r_out0_valid;
    logic          r_out1_valid;
    logic          w_tag;
    logic          w_hs;
    logic          w_rd;

    // A held word blocks both flows until its own consumer takes it.
    assign w_tag = r_out_reg[DATA_W];
    assign w_hs  = (r_state == R_HOLD) && (w_tag ? out1_ready : out0_ready);
    assign w_rd  = rst && !fifo_empty && ((r_state == R_IDLE) || w_hs);

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            r_state      <= R_IDLE;
            r_out_reg    <= '0;
            r_out0_valid <= 1'b0;
            r_out1_valid <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (w_rd) r_state <= R_WAIT;
                end
                R_WAIT: begin
                    r_out_reg    <= fifo_dataout;
                    r_out0_valid <= (fifo_dataout[DATA_W] == TAG_FLOW0);
                    r_out1_valid <= (fifo_dataout[DATA_W] == TAG_FLOW1);
                    r_state      <= R_HOLD;
                end
                R_HOLD: begin
                    if (w_hs) begin
                        r_out0_valid <= 1'b0;
                        r_out1_valid <= 1'b0;
                        r_state      <= w_rd ? R_WAIT : R_IDLE;
                    end
                end
                default: begin
                    r_state      <= R_IDLE;
                    r_out0_valid <= 1'b0;
                    r_out1_valid <= 1'b0;
                end
            endcase
        end
    end

    assign fifo_rd    = w_rd;
    assign out0_valid = r_out0_valid;
    assign out1_valid = r_out1_valid;
    assign out0_data  = r_out_reg[DATA_W-1:0];
    assign out1_data  = r_out_reg[DATA_W-1:0];

endmodule

// File: tb/tb_fifo_mono_arbiter.sv
// tb/tb_fifo_mono_arbiter.sv - randomized scoreboard bench for fifo_mono_arbiter with an 8-deep FIFO model
module tb_fifo_mono_arbiter;

    logic        ck = 1'b0;
    logic        rst;
    logic        in0_valid, in1_valid, in0_ready, in1_ready;
    logic [6:0]  in0_data, in1_data;
    logic        fifo_wr, fifo_full, fifo_rd, fifo_empty;
    logic [7:0]  fifo_datain, fifo_dataout;
    logic        out0_valid, out1_valid, out0_ready, out1_ready;
    logic [6:0]  out0_data, out1_data;
    logic [15:0] cnt0, cnt1;

    always #5 ck = ~ck;

    fifo_mono_arbiter dut (
        .ck(ck), .rst(rst),
        .in0_valid(in0_valid), .in0_data(in0_data), .in0_ready(in0_ready),
        .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(in1_ready),
        .fifo_wr(fifo_wr), .fifo_datain(fifo_datain), .fifo_full(fifo_full),
        .fifo_rd(fifo_rd), .fifo_dataout(fifo_dataout), .fifo_empty(fifo_empty),
        .out0_valid(out0_valid), .out0_data(out0_data), .out0_ready(out0_ready),
        .out1_valid(out1_valid), .out1_data(out1_data), .out1_ready(out1_ready),
        .cnt0(cnt0), .cnt1(cnt1)
    );

    // Shared 8-deep FIFO; head is registered on a read.
    logic [7:0] fmem [8];
    int fcnt, frd, fwr;
    assign fifo_full  = (fcnt == 8);
    assign fifo_empty = (fcnt == 0);

    always @(posedge ck or negedge rst) begin
        if (!rst) begin
            fcnt <= 0; frd <= 0; fwr <= 0; fifo_dataout <= 8'h00;
        end else begin
            if (fifo_rd && fcnt > 0) begin
                fifo_dataout <= fmem[frd];
                frd <= (frd + 1) % 8;
            end
            if (fifo_wr && fcnt < 8) begin
                fmem[fwr] <= fifo_datain;
                fwr <= (fwr + 1) % 8;
            end
            fcnt <= fcnt + ((fifo_wr && fcnt < 8) ? 1 : 0) - ((fifo_rd && fcnt > 0) ? 1 : 0);
        end
    end

    int         n_pass = 0;
    int         n_total = 0;
    bit         m_prio = 1'b0;
    logic [15:0] m_cnt0 = '0;
    logic [15:0] m_cnt1 = '0;
    logic [6:0] exp0 [$];
    logic [6:0] exp1 [$];

    task automatic chk(input string nm, input longint act, input longint req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    endtask

    task automatic cycle(input bit v0, input logic [6:0] d0, input bit v1, input logic [6:0] d1,
                         input bit r0, input bit r1);
        bit e0, e1, g0, g1;
        @(negedge ck);
        in0_valid = v0; in0_data = d0; in1_valid = v1; in1_data = d1;
        out0_ready = r0; out1_ready = r1;
        #1;
        e0 = v0 && !fifo_full;
        e1 = v1 && !fifo_full;
        g0 = e0 && (!e1 || m_prio == 1'b0);
        g1 = e1 && (!e0 || m_prio == 1'b1);
        chk("cnt0", cnt0, m_cnt0);
        chk("cnt1", cnt1, m_cnt1);
        chk("in0_ready", in0_ready, g0);
        chk("in1_ready", in1_ready, g1);
        chk("fifo_wr", fifo_wr, g0 | g1);
        if (g0) begin
            chk("datain0", fifo_datain, {1'b0, d0});
            exp0.push_back(d0); m_cnt0 += 16'd1; m_prio = 1'b1;
        end else if (g1) begin
            chk("datain1", fifo_datain, {1'b1, d1});
            exp1.push_back(d1); m_cnt1 += 16'd1; m_prio = 1'b0;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 80 && (exp0.size() > 0 || exp1.size() > 0); i++)
            cycle(1'b0, 7'd0, 1'b0, 7'd0, 1'b1, 1'b1);
        repeat (3) cycle(1'b0, 7'd0, 1'b0, 7'd0, 1'b1, 1'b1);
        chk("drain_flow0", exp0.size(), 0);
        chk("drain_flow1", exp1.size(), 0);
    endtask

    // Read-side monitor: per-flow order, pop-to-valid latency, stall and throughput rules.
    initial begin
        int cyc;
        int pop_cyc;
        bit pv, vld, hs;
        cyc = 0; pop_cyc = -100; pv = 1'b0;
        forever begin
            @(negedge ck);
            #2;
            cyc++;
            if (!rst) begin
                chk("rst_out0_valid", out0_valid, 0);
                chk("rst_out1_valid", out1_valid, 0);
                chk("rst_fifo_rd", fifo_rd, 0);
                pv = 1'b0;
            end else begin
                chk("both_valid", out0_valid & out1_valid, 0);
                chk("rd_when_empty", fifo_rd & fifo_empty, 0);
                vld = out0_valid | out1_valid;
                hs  = (out0_valid && out0_ready) || (out1_valid && out1_ready);
                if (vld && !pv) chk("pop_to_valid", cyc - pop_cyc, 2);
                if (fifo_rd) pop_cyc = cyc;
                if (out0_valid) begin
                    chk("out0_expected", exp0.size() > 0, 1);
                    if (exp0.size() > 0) begin
                        chk("out0_data", out0_data, exp0[0]);
                        if (out0_ready) void'(exp0.pop_front());
                    end
                end
                if (out1_valid) begin
                    chk("out1_expected", exp1.size() > 0, 1);
                    if (exp1.size() > 0) begin
                        chk("out1_data", out1_data, exp1[0]);
                        if (out1_ready) void'(exp1.pop_front());
                    end
                end
                if (hs && !fifo_empty) chk("rd_after_hs", fifo_rd, 1);
                if (vld && !hs) chk("no_rd_stall", fifo_rd, 0);
                pv = vld;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        in0_valid = 1'b1; in0_data = 7'h7f; in1_valid = 1'b1; in1_data = 7'h55;
        out0_ready = 1'b1; out1_ready = 1'b1;
        #6 rst = 1'b0;
        #3;
        chk("reset_in0_ready", in0_ready, 0);
        chk("reset_in1_ready", in1_ready, 0);
        chk("reset_fifo_wr", fifo_wr, 0);
        chk("reset_fifo_rd", fifo_rd, 0);
        chk("reset_cnt0", cnt0, 0);
        chk("reset_cnt1", cnt1, 0);
        chk("reset_out0_valid", out0_valid, 0);
        chk("reset_out1_valid", out1_valid, 0);
        #2 rst = 1'b1; in0_valid = 1'b0; in1_valid = 1'b0;

        repeat (8) cycle(1'b1, 7'd1, 1'b1, 7'd2, 1'b1, 1'b1);
        drain();

        repeat (14) cycle(1'b1, 7'($urandom), 1'b1, 7'($urandom), 1'b0, 1'b0);
        drain();

        cycle(1'b0, 7'd0, 1'b1, 7'd1, 1'b0, 1'b0);
        cycle(1'b1, 7'd2, 1'b0, 7'd0, 1'b0, 1'b0);
        cycle(1'b0, 7'd0, 1'b1, 7'd3, 1'b0, 1'b0);
        drain();

        cycle(1'b1, 7'd5, 1'b0, 7'd0, 1'b0, 1'b0);
        cycle(1'b0, 7'd0, 1'b1, 7'd9, 1'b0, 1'b0);
        repeat (6) cycle(1'b0, 7'd0, 1'b0, 7'd0, 1'b0, 1'b1);
        drain();

        for (int i = 0; i < 300; i++)
            cycle(1'($urandom % 2), 7'($urandom), 1'($urandom % 2), 7'($urandom),
                  1'(($urandom % 4) != 0), 1'(($urandom % 4) != 0));
        drain();

        for (int i = 0; i < 20; i++)
            cycle(1'b1, 7'($urandom), 1'b1, 7'($urandom), 1'b1, 1'b1);
        drain();

        cycle(1'b1, 7'h11, 1'b0, 7'd0, 1'b0, 1'b0);
        repeat (4) cycle(1'b0, 7'd0, 1'b0, 7'd0, 1'b0, 1'b0);
        @(negedge ck);
        #3;
        in0_valid = 1'b1; in1_valid = 1'b1;
        rst = 1'b0;
        exp0.delete(); exp1.delete();
        m_prio = 1'b0; m_cnt0 = '0; m_cnt1 = '0;
        #1;
        chk("midrst_out0_valid", out0_valid, 0);
        chk("midrst_out1_valid", out1_valid, 0);
        chk("midrst_cnt0", cnt0, 0);
        chk("midrst_cnt1", cnt1, 0);
        chk("midrst_in0_ready", in0_ready, 0);
        chk("midrst_in1_ready", in1_ready, 0);
        chk("midrst_fifo_wr", fifo_wr, 0);
        @(negedge ck);
        #3;
        rst = 1'b1; in0_valid = 1'b0; in1_valid = 1'b0;

        repeat (6) cycle(1'b1, 7'($urandom), 1'b1, 7'($urandom), 1'b1, 1'b1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
